// File: rtl/dbg_wb_trace.sv
// Writeback-trace transmitter: buffers register-write events in a FIFO and
// serialises each one into a 5-beat 32-bit valid/ready packet; overflow drops and counts.
module dbg_wb_trace #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [63:0] wb_pc,
    input  logic [4:0]  wb_rd,
    input  logic [63:0] wb_data,
    output logic        tr_valid,
    input  logic        tr_ready,
    output logic [31:0] tr_data,
    output logic        tr_last,
    output logic [15:0] drop_cnt,
    output logic        busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic [15:0] seq;
        logic [4:0]  rd;
        logic [63:0] pc;
        logic [63:0] data;
    } event_t;

    typedef enum logic {IDLE, SEND} state_t;

    event_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    event_t           hr;
    logic [2:0]       beat;
    logic [15:0]      seq;
    state_t           state, state_nxt;
    logic             fifo_empty, event_in, push, pop, fire;

    function automatic logic [31:0] beat_word(input event_t e, input logic [2:0] b);
        case (b)
            3'd0:    beat_word = {e.seq, 3'b000, e.rd, 8'hA5};
            3'd1:    beat_word = e.pc[31:0];
            3'd2:    beat_word = e.pc[63:32];
            3'd3:    beat_word = e.data[31:0];
            default: beat_word = e.data[63:32];
        endcase
    endfunction

    assign fifo_empty = (count == '0);
    assign event_in   = wb_valid && (wb_rd != 5'd0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push       = event_in && ((count != FULL_CNT) || pop);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latches).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!fifo_empty) state_nxt = SEND;
            SEND: if (fire && beat == 3'd4 && fifo_empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fire = (state == SEND) && tr_ready;
        pop  = !fifo_empty && ((state == IDLE) || (fire && beat == 3'd4));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is not reset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{seq: seq, rd: wb_rd, pc: wb_pc, data: wb_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hr       <= '0;
            beat     <= '0;
            seq      <= '0;
            drop_cnt <= '0;
            tr_data  <= '0;
            tr_last  <= 1'b0;
        end else begin
            if (event_in) seq <= seq + 16'd1;
            if (event_in && !push && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (pop) begin
                hr      <= mem[rd_ptr];
                beat    <= 3'd0;
                tr_data <= beat_word(mem[rd_ptr], 3'd0);
                tr_last <= 1'b0;
            end else if (fire && beat != 3'd4) begin
                beat    <= beat + 3'd1;
                tr_data <= beat_word(hr, beat + 3'd1);
                tr_last <= (beat == 3'd3);
            end else if (fire) begin
                tr_data <= '0;
                tr_last <= 1'b0;
            end
        end
    end

    assign tr_valid = (state == SEND);
    assign busy     = !fifo_empty || (state == SEND);

endmodule
